// File: rtl/vga_timing_out.sv
// VGA timing generator merged with the pixel output register. Sync and
// active-area flags are delayed to line up with the controller's colour data.
module vga_timing_out #(
  parameter int unsigned  H_ACTIVE  = 640,
  parameter int unsigned  H_FP      = 16,
  parameter int unsigned  H_SYNC    = 96,
  parameter int unsigned  H_BP      = 48,
  parameter int unsigned  V_ACTIVE  = 480,
  parameter int unsigned  V_FP      = 10,
  parameter int unsigned  V_SYNC    = 2,
  parameter int unsigned  V_BP      = 33,
  parameter bit           HSYNC_POL = 1'b0,
  parameter bit           VSYNC_POL = 1'b0,
  parameter int unsigned  COLOR_W   = 12,
  parameter int unsigned  PIPE_DLY  = 2,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned XW        = $clog2(H_TOTAL),
  localparam int unsigned YW        = $clog2(V_TOTAL)
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic               run,
  input  logic [COLOR_W-1:0] color_data,
  output logic [XW-1:0]      x_pos,
  output logic [YW-1:0]      y_pos,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] rgb_out,
  output logic               h_sync,
  output logic               v_sync,
  output logic               video_enable
);

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_DE_END = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_DE_END = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          de0, hs0, vs0;
  logic          de_d, hs_d, vs_d;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (run) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // A paused generator emits blank, non-sync pixels.
  always_comb begin
    de0 = run && (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
    hs0 = run && (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs0 = run && (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  assign x_pos       = h_cnt;
  assign y_pos       = v_cnt;
  assign line_start  = run && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);

  // Stages hold asserted-sense flags; cleared stages therefore read as blank.
  if (PIPE_DLY == 0) begin : g_no_dly
    assign {de_d, hs_d, vs_d} = {de0, hs0, vs0};
  end else if (PIPE_DLY == 1) begin : g_one_dly
    logic [2:0] shift_q;
    always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) shift_q <= '0;
      else       shift_q <= {de0, hs0, vs0};
    end
    assign {de_d, hs_d, vs_d} = shift_q;
  end else begin : g_multi_dly
    logic [3*PIPE_DLY-1:0] shift_q;
    always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) shift_q <= '0;
      else       shift_q <= {shift_q[3*PIPE_DLY-4:0], de0, hs0, vs0};
    end
    assign {de_d, hs_d, vs_d} = shift_q[3*PIPE_DLY-1 -: 3];
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      rgb_out      <= '0;
      video_enable <= 1'b0;
      h_sync       <= ~HSYNC_POL;
      v_sync       <= ~VSYNC_POL;
    end else begin
      rgb_out      <= de_d ? color_data : '0;
      video_enable <= de_d;
      h_sync       <= ~(hs_d ^ HSYNC_POL);
      v_sync       <= ~(vs_d ^ VSYNC_POL);
    end
  end

endmodule

// File: tb/tb_vga_timing_out.sv
// Directed bench for vga_timing_out: default 640x480 timing with pause/reset
// control, a 320x240 positive-sync zero-latency instance, and a tiny frame.
module tb_vga_timing_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- default timing instance ----------------
  logic        rst0, run0;
  logic [11:0] col0, rgb0, c0_d1, c0_d2;
  logic [9:0]  x0, y0;
  logic        ls0, fs0, hs0p, vs0p, ve0;

  vga_timing_out dut0 (
    .pixel_clk(clk), .reset(rst0), .run(run0), .color_data(col0),
    .x_pos(x0), .y_pos(y0), .line_start(ls0), .frame_start(fs0),
    .rgb_out(rgb0), .h_sync(hs0p), .v_sync(vs0p), .video_enable(ve0)
  );

  // Graphics controller stand-in: colour for a coordinate returned two cycles later.
  always @(posedge clk) begin
    c0_d1 <= {x0[3:0], y0[3:0], 4'hA};
    c0_d2 <= c0_d1;
  end
  assign col0 = c0_d2;

  // ---------------- 320x240, positive syncs, no delay ----------------
  logic       rst1, run1;
  logic [7:0] col1, rgb1;
  logic [8:0] x1;
  logic [7:0] y1;
  logic       ls1, fs1, hs1, vs1, ve1;

  vga_timing_out #(
    .H_ACTIVE(320), .H_FP(8), .H_SYNC(48), .H_BP(24),
    .V_ACTIVE(240), .V_FP(3), .V_SYNC(4), .V_BP(6),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COLOR_W(8), .PIPE_DLY(0)
  ) dut1 (
    .pixel_clk(clk), .reset(rst1), .run(run1), .color_data(col1),
    .x_pos(x1), .y_pos(y1), .line_start(ls1), .frame_start(fs1),
    .rgb_out(rgb1), .h_sync(hs1), .v_sync(vs1), .video_enable(ve1)
  );
  assign col1 = x1[7:0];

  // ---------------- tiny 16x12 frame, three-stage delay ----------------
  logic        rst2, run2;
  logic [11:0] rgb2;
  logic [3:0]  x2, y2;
  logic        ls2, fs2, hs2, vs2, ve2;

  vga_timing_out #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .PIPE_DLY(3)
  ) dut2 (
    .pixel_clk(clk), .reset(rst2), .run(run2), .color_data(12'h5A5),
    .x_pos(x2), .y_pos(y2), .line_start(ls2), .frame_start(fs2),
    .rgb_out(rgb2), .h_sync(hs2), .v_sync(vs2), .video_enable(ve2)
  );

  // ---------------- reference model for dut0 ----------------
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } ent_t;

  ent_t h0, h1, h2;
  int   mx, my, k0;

  task automatic model0_reset();
    mx = 0; my = 0; k0 = 0;
    h0 = '0; h1 = '0; h2 = '0;
  endtask

  // One pixel clock on dut0; run0 for this cycle is set by the caller beforehand.
  task automatic tick0();
    ent_t e;
    e.de  = run0 && (mx < 640) && (my < 480);
    e.hs  = run0 && (mx >= 656) && (mx < 752);
    e.vs  = run0 && (my >= 490) && (my < 492);
    e.rgb = e.de ? {4'(mx), 4'(my), 4'hA} : 12'h000;
    h2 = h1; h1 = h0; h0 = e;
    @(posedge clk);
    if (run0) begin
      if (mx == 799) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    k0++;
    @(negedge clk);
    check("x0", x0, mx);
    check("y0", y0, my);
    check("ve0", ve0, h2.de);
    check("rgb0", rgb0, h2.rgb);
    check("hs0", hs0p, !h2.hs);
    check("vs0", vs0p, !h2.vs);
    check("ls0", ls0, run0 && (mx == 0));
    check("fs0", fs0, run0 && (mx == 0) && (my == 0));
    if (k0 == 3)   check("first_pixel", rgb0, 12'h00A);
    if (k0 == 658) check("hs_before_fall", hs0p, 1);
    if (k0 == 659) check("hs_fall", hs0p, 0);
    if (k0 == 754) check("hs_still_low", hs0p, 0);
    if (k0 == 755) check("hs_rise", hs0p, 1);
    if (k0 == 799) check("ls_before_period", ls0, 0);
    if (k0 == 800) check("ls_period", ls0, 1);
  endtask

  int   sx, sy, src, vs_low, fs_cnt;
  logic e_de, e_hs, e_vs;

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    run0 = 1'b1; run1 = 1'b1; run2 = 1'b1;
    #1;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_x0", x0, 0);
    check("rst_y0", y0, 0);
    check("rst_rgb0", rgb0, 0);
    check("rst_ve0", ve0, 0);
    check("rst_hs0", hs0p, 1);
    check("rst_vs0", vs0p, 1);
    check("rst_hs1_idle_low", hs1, 0);
    check("rst_vs1_idle_low", vs1, 0);
    check("rst_ve1", ve1, 0);
    check("rst_hs2", hs2, 1);
    check("rst_ve2", ve2, 0);

    // Default timing: first two lines, then pause at the end of line 1.
    rst0 = 1'b0;
    model0_reset();
    while (!(mx == 799 && my == 1)) tick0();
    run0 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick0();
      if (i == 2) begin
        check("pause_hold_x", x0, 799);
        check("pause_hold_y", y0, 1);
        check("pause_ve", ve0, 0);
        check("pause_hs", hs0p, 1);
        check("pause_vs", vs0p, 1);
      end
    end
    run0 = 1'b1;
    tick0();
    check("resume_wrap_x", x0, 0);
    check("resume_wrap_y", y0, 2);

    // Pause inside the active area and inside the hsync pulse.
    while (!(mx == 100 && my == 2)) tick0();
    run0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick0();
      if (i == 1) check("pause_active_tail", ve0, 1);
      if (i == 2) check("pause_active_blank", ve0, 0);
    end
    run0 = 1'b1;
    while (!(mx == 700 && my == 2)) tick0();
    run0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick0();
      if (i == 1) check("pause_hs_tail", hs0p, 0);
      if (i == 2) check("pause_hs_inactive", hs0p, 1);
    end
    run0 = 1'b1;

    // Asynchronous reset mid-line.
    while (!(mx == 300 && my == 3)) tick0();
    check("pre_rst_ve", ve0, 1);
    #2 rst0 = 1'b1;
    #1;
    check("async_rst_x", x0, 0);
    check("async_rst_y", y0, 0);
    check("async_rst_rgb", rgb0, 0);
    check("async_rst_ve", ve0, 0);
    check("async_rst_hs", hs0p, 1);
    check("async_rst_vs", vs0p, 1);
    @(posedge clk);
    #1 check("rst_hold_x", x0, 0);
    @(negedge clk);
    rst0 = 1'b0;
    model0_reset();
    repeat (20) tick0();
    check("restart_x", x0, 20);
    check("restart_y", y0, 0);

    // 320x240: one-cycle latency, positive syncs, 400-pixel lines.
    rst1 = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      @(negedge clk);
      sx = (k - 1) % 400;
      sy = (k - 1) / 400;
      e_de = (sx < 320) && (sy < 240);
      check("x1", x1, k % 400);
      check("y1", y1, k / 400);
      check("ve1", ve1, e_de);
      check("rgb1", rgb1, e_de ? 8'(sx) : 8'h00);
      check("hs1", hs1, (sx >= 328) && (sx < 376));
      check("vs1", vs1, 0);
      check("ls1", ls1, (k % 400) == 0);
    end

    // Tiny frame: 16x12, four-cycle latency, two full frames.
    rst2 = 1'b0;
    vs_low = 0;
    fs_cnt = 0;
    for (int k = 1; k <= 394; k++) begin
      @(posedge clk);
      @(negedge clk);
      src = k - 4;
      if (src < 0) begin
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
      end else begin
        sx = src % 16;
        sy = (src / 16) % 12;
        e_de = (sx < 10) && (sy < 6);
        e_hs = (sx >= 12) && (sx < 15);
        e_vs = (sy >= 8) && (sy < 10);
      end
      check("x2", x2, k % 16);
      check("y2", y2, (k / 16) % 12);
      check("ve2", ve2, e_de);
      check("rgb2", rgb2, e_de ? 12'h5A5 : 12'h000);
      check("hs2", hs2, !e_hs);
      check("vs2", vs2, !e_vs);
      check("fs2", fs2, (k % 192) == 0);
      if (k >= 4 && k < 196 && !vs2) vs_low++;
      if (fs2) fs_cnt++;
    end
    check("vs2_cycles_per_frame", vs_low, 32);
    check("fs2_pulse_count", fs_cnt, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
